// File: rtl/sample_0_ext_mailbox_if.sv
//------------------------------------------------------------------------------
// Module  : sample_0_ext_mailbox_if
// Purpose : Bus bundle between the sample_0 external-register window (master)
//           and a window target such as the mailbox (slave).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sample_0_ext_mailbox_if;
   logic        i_request;
   logic [7:0]  i_address;
   logic        i_direction;
   logic [31:0] i_write_data;
   logic        o_done;
   logic [31:0] o_read_data;
   logic [1:0]  o_status;

   modport master (
      output i_request, i_address, i_direction, i_write_data,
      input  o_done, o_read_data, o_status
   );

   modport slave (
      input  i_request, i_address, i_direction, i_write_data,
      output o_done, o_read_data, o_status
   );
endinterface

`default_nettype wire

// File: rtl/sample_0_ext_mailbox.sv
//------------------------------------------------------------------------------
// Module  : sample_0_ext_mailbox
// Purpose : Mailbox on the sample_0 external-register window. A TX FIFO is
//           filled by register pushes and drained by a valid/ready stream; an
//           RX FIFO is filled by a stream and drained by register pops.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_0_ext_mailbox #(
   parameter logic [7:0] BASE_ADDRESS = 8'h80,
   parameter int         DEPTH        = 8,
   parameter int         DATA_WIDTH   = 32
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   sample_0_ext_mailbox_if.slave      bus,
   output logic                       o_tx_valid,
   output logic [DATA_WIDTH-1:0]      o_tx_data,
   input  wire logic                  i_tx_ready,
   input  wire logic                  i_rx_valid,
   input  wire logic [DATA_WIDTH-1:0] i_rx_data,
   output logic                       o_rx_ready,
   output logic                       o_rx_irq
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [1:0] C_OK  = 2'b00;
   localparam logic [1:0] C_ERR = 2'b10;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            status_q, status_d;

   logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
   logic [PW-1:0]         tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

   logic [7:0]  w_diff;
   logic [6:0]  w_off;
   logic        w_access;
   logic        w_tx_push, w_tx_pop, w_tx_flush;
   logic        w_rx_push, w_rx_pop, w_rx_flush;
   logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [31:0] w_status_word;

   assign w_tx_full  = (tx_cnt_q == C_FULL);
   assign w_tx_empty = (tx_cnt_q == '0);
   assign w_rx_full  = (rx_cnt_q == C_FULL);
   assign w_rx_empty = (rx_cnt_q == '0);

   assign o_tx_valid = ~w_tx_empty;
   assign o_tx_data  = w_tx_empty ? '0 : tx_mem_q[tx_rd_q];
   assign o_rx_ready = ~w_rx_full;
   assign o_rx_irq   = ~w_rx_empty;

   assign bus.o_done      = (state_q == S_RESP);
   assign bus.o_read_data = rdata_q;
   assign bus.o_status    = status_q;

   assign w_status_word = {12'd0, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full,
                           8'(rx_cnt_q), 8'(tx_cnt_q)};

   // Stream-side handshakes; flush on the same FIFO overrides them below.
   assign w_tx_pop  = o_tx_valid & i_tx_ready;
   assign w_rx_push = i_rx_valid & o_rx_ready;

   // Register decode: an access is performed in the IDLE cycle it is seen.
   always_comb begin
      w_diff     = bus.i_address - BASE_ADDRESS;
      w_off      = w_diff[6:0];
      w_access   = (state_q == S_IDLE) & bus.i_request;
      rdata_d    = rdata_q;
      status_d   = status_q;
      w_tx_push  = 1'b0;
      w_rx_pop   = 1'b0;
      w_tx_flush = 1'b0;
      w_rx_flush = 1'b0;
      if (w_access) begin
         rdata_d  = '0;
         status_d = C_OK;
         if (w_diff[7]) begin
            status_d = C_ERR;
         end else begin
            case (w_off)
               7'h00: begin
                  if (bus.i_direction) begin
                     if (w_tx_full) status_d  = C_ERR;
                     else           w_tx_push = 1'b1;
                  end
               end
               7'h04: begin
                  if (!bus.i_direction) begin
                     if (w_rx_empty) begin
                        status_d = C_ERR;
                     end else begin
                        w_rx_pop = 1'b1;
                        rdata_d  = rx_mem_q[rx_rd_q];
                     end
                  end
               end
               7'h08: begin
                  if (!bus.i_direction) rdata_d = w_status_word;
               end
               7'h0C: begin
                  if (bus.i_direction) begin
                     w_tx_flush = bus.i_write_data[0];
                     w_rx_flush = bus.i_write_data[1];
                  end
               end
               default: status_d = C_ERR;
            endcase
         end
      end
   end

   // Next-state logic: every access gets exactly one RESP (done) cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.i_request) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO occupancy: flush wins over any concurrent push or pop.
   always_comb begin
      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      case ({w_tx_push, w_tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
         2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
         default: tx_cnt_d = tx_cnt_q;
      endcase
      case ({w_rx_push, w_rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
         2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
         default: rx_cnt_d = rx_cnt_q;
      endcase
      if (w_tx_flush) tx_cnt_d = '0;
      if (w_rx_flush) rx_cnt_d = '0;
   end

   // FSM state and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rdata_q  <= '0;
         status_q <= C_OK;
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
      end
   end

   // FIFO pointers and counts; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         if (w_tx_flush) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
         end else begin
            if (w_tx_push) tx_wr_q <= tx_wr_q + PW'(1);
            if (w_tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
         end
         if (w_rx_flush) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
         end else begin
            if (w_rx_push) rx_wr_q <= rx_wr_q + PW'(1);
            if (w_rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
         end
      end
   end

   // FIFO storage; contents are don't-care while not counted.
   always_ff @(posedge clk) begin
      if (w_tx_push && !w_tx_flush) tx_mem_q[tx_wr_q] <= bus.i_write_data;
      if (w_rx_push && !w_rx_flush) rx_mem_q[rx_wr_q] <= i_rx_data;
   end

endmodule

`default_nettype wire

// File: tb/tb_sample_0_ext_mailbox.sv
//------------------------------------------------------------------------------
// Module  : tb_sample_0_ext_mailbox
// Purpose : Directed self-checking bench for sample_0_ext_mailbox.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_0_ext_mailbox;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_tx_ready = 1'b0;
   logic        i_rx_valid = 1'b0;
   logic [31:0] i_rx_data  = '0;
   logic        o_tx_valid;
   logic [31:0] o_tx_data;
   logic        o_rx_ready;
   logic        o_rx_irq;

   int n_checks = 0;
   int n_errors = 0;

   sample_0_ext_mailbox_if bif ();

   sample_0_ext_mailbox #(
      .BASE_ADDRESS (8'h80),
      .DEPTH        (8),
      .DATA_WIDTH   (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bif),
      .o_tx_valid (o_tx_valid),
      .o_tx_data  (o_tx_data),
      .i_tx_ready (i_tx_ready),
      .i_rx_valid (i_rx_valid),
      .i_rx_data  (i_rx_data),
      .o_rx_ready (o_rx_ready),
      .o_rx_irq   (o_rx_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One bus access; s_tx / s_rx hold a stream strobe for the access edge only.
   task automatic bus_xfer(input logic dir, input logic [7:0] addr, input logic [31:0] wd,
                           input logic s_tx, input logic s_rx, input logic [31:0] s_rx_data,
                           output logic [31:0] rd, output logic [1:0] st);
      bit got;
      got = 0;
      rd  = '0;
      st  = 2'b11;
      @(negedge clk);
      bif.i_request    = 1'b1;
      bif.i_address    = addr;
      bif.i_direction  = dir;
      bif.i_write_data = wd;
      i_tx_ready       = s_tx;
      i_rx_valid       = s_rx;
      i_rx_data        = s_rx_data;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk);
         #1;
         i_tx_ready = 1'b0;
         i_rx_valid = 1'b0;
         if (bif.o_done) begin
            got = 1;
            rd  = bif.o_read_data;
            st  = bif.o_status;
         end
      end
      if (!got) check("bus_timeout", {31'd0, got}, 32'd1);
      @(negedge clk);
      bif.i_request = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] addr, input logic [31:0] wd, output logic [1:0] st);
      logic [31:0] rd;
      bus_xfer(1'b1, addr, wd, 1'b0, 1'b0, 32'd0, rd, st);
   endtask

   task automatic bus_rd(input logic [7:0] addr, output logic [31:0] rd, output logic [1:0] st);
      bus_xfer(1'b0, addr, 32'd0, 1'b0, 1'b0, 32'd0, rd, st);
   endtask

   logic [31:0] rd;
   logic [1:0]  st;
   logic [31:0] q[$];
   logic [31:0] exp_head;

   initial begin
      bif.i_request    = 1'b0;
      bif.i_address    = '0;
      bif.i_direction  = 1'b0;
      bif.i_write_data = '0;

      // Reset values
      #1;
      check("rst_done",     {31'd0, bif.o_done}, 32'd0);
      check("rst_rdata",    bif.o_read_data, 32'd0);
      check("rst_status",   {30'd0, bif.o_status}, 32'd0);
      check("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
      check("rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
      check("rst_irq",      {31'd0, o_rx_irq}, 32'd0);
      check("rst_tx_data",  o_tx_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset during RESP of a TX push: done drops at once, push discarded
      @(negedge clk);
      bif.i_request    = 1'b1;
      bif.i_address    = 8'h80;
      bif.i_direction  = 1'b1;
      bif.i_write_data = 32'hDEAD;
      @(posedge clk);
      #1;
      check("mid_done_hi", {31'd0, bif.o_done}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_done_lo", {31'd0, bif.o_done}, 32'd0);
      @(negedge clk);
      bif.i_request = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus_rd(8'h88, rd, st);
      check("mid_status_word", rd, 32'h000A_0000);
      check("mid_status_ok", {30'd0, st}, 32'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, bif.o_done}, 32'd0);

      // TX fill to DEPTH, overflow rejected
      for (int i = 1; i <= 8; i++) begin
         bus_wr(8'h80, i, st);
         check("tx_fill_st", {30'd0, st}, 32'd0);
      end
      bus_wr(8'h80, 32'd9, st);
      check("tx_over_st", {30'd0, st}, 32'd2);
      bus_rd(8'h88, rd, st);
      check("tx_full_word", rd, 32'h0009_0008);

      // TX drain in order
      @(negedge clk);
      i_tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("tx_drain_valid", {31'd0, o_tx_valid}, 32'd1);
         check("tx_drain_data", o_tx_data, i);
         @(negedge clk);
      end
      i_tx_ready = 1'b0;
      check("tx_drained", {31'd0, o_tx_valid}, 32'd0);

      // RX path: three stream words, then register pops
      @(negedge clk);
      i_rx_valid = 1'b1;
      i_rx_data  = 32'hA0A0_0001;
      @(negedge clk);
      i_rx_data  = 32'hB0B0_0002;
      @(negedge clk);
      i_rx_data  = 32'hC0C0_0003;
      @(negedge clk);
      i_rx_valid = 1'b0;
      check("rx_irq_set", {31'd0, o_rx_irq}, 32'd1);
      bus_rd(8'h88, rd, st);
      check("rx_count_word", rd, 32'h0002_0300);
      bus_rd(8'h84, rd, st);
      check("rx_pop_a", rd, 32'hA0A0_0001);
      check("rx_pop_a_st", {30'd0, st}, 32'd0);
      bus_rd(8'h84, rd, st);
      check("rx_pop_b", rd, 32'hB0B0_0002);
      bus_rd(8'h84, rd, st);
      check("rx_pop_c", rd, 32'hC0C0_0003);
      check("rx_pop_c_st", {30'd0, st}, 32'd0);
      bus_rd(8'h84, rd, st);
      check("rx_empty_data", rd, 32'd0);
      check("rx_empty_st", {30'd0, st}, 32'd2);
      check("rx_irq_clr", {31'd0, o_rx_irq}, 32'd0);

      // Simultaneous TX push + stream pop across pointer wrap
      for (int i = 0; i < 4; i++) begin
         bus_wr(8'h80, 32'd100 + i, st);
         q.push_back(32'd100 + i);
      end
      for (int it = 0; it < 20; it++) begin
         exp_head = q[0];
         check("sim_head", o_tx_data, exp_head);
         bus_xfer(1'b1, 8'h80, 32'd200 + it, 1'b1, 1'b0, 32'd0, rd, st);
         check("sim_st", {30'd0, st}, 32'd0);
         void'(q.pop_front());
         q.push_back(32'd200 + it);
         bus_rd(8'h88, rd, st);
         check("sim_count", {24'd0, rd[7:0]}, 32'd4);
      end
      exp_head = q[0];
      check("sim_head_final", o_tx_data, exp_head);

      // RX flush racing a stream push: flush wins, word dropped
      @(negedge clk);
      i_rx_valid = 1'b1;
      i_rx_data  = 32'h0000_0011;
      @(negedge clk);
      i_rx_valid = 1'b0;
      check("pre_flush_irq", {31'd0, o_rx_irq}, 32'd1);
      bus_xfer(1'b1, 8'h8C, 32'h2, 1'b0, 1'b1, 32'h0000_0055, rd, st);
      check("rx_flush_st", {30'd0, st}, 32'd0);
      check("rx_flush_irq", {31'd0, o_rx_irq}, 32'd0);
      bus_wr(8'h8C, 32'h1, st);
      check("tx_flush_valid", {31'd0, o_tx_valid}, 32'd0);
      bus_rd(8'h88, rd, st);
      check("flush_word", rd, 32'h000A_0000);
      bus_rd(8'h84, rd, st);
      check("flush_rx_st", {30'd0, st}, 32'd2);

      // RX fill to DEPTH: ready deasserts, count saturates at 8
      @(negedge clk);
      i_rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         i_rx_data = 32'h300 + i;
         @(negedge clk);
      end
      i_rx_valid = 1'b0;
      check("rx_full_ready", {31'd0, o_rx_ready}, 32'd0);
      bus_rd(8'h88, rd, st);
      check("rx_full_word", rd, 32'h0006_0800);
      bus_rd(8'h84, rd, st);
      check("rx_full_head", rd, 32'h300);
      check("rx_ready_back", {31'd0, o_rx_ready}, 32'd1);
      bus_wr(8'h8C, 32'h2, st);

      // Decode: benign accesses and bad offsets
      bus_wr(8'h80, 32'h77, st);
      bus_rd(8'h88, rd, st);
      check("dec_word_before", rd, 32'h0008_0001);
      bus_rd(8'h90, rd, st);
      check("dec_rd_data", rd, 32'd0);
      check("dec_rd_st", {30'd0, st}, 32'd2);
      bus_wr(8'hFC, 32'hFFFF_FFFF, st);
      check("dec_wr_st", {30'd0, st}, 32'd2);
      bus_wr(8'h88, 32'hFFFF_FFFF, st);
      check("dec_status_wr_st", {30'd0, st}, 32'd0);
      bus_wr(8'h84, 32'h1234, st);
      check("dec_rxdata_wr_st", {30'd0, st}, 32'd0);
      bus_rd(8'h80, rd, st);
      check("dec_txdata_rd", rd, 32'd0);
      check("dec_txdata_rd_st", {30'd0, st}, 32'd0);
      bus_rd(8'h8C, rd, st);
      check("dec_ctrl_rd", rd, 32'd0);
      bus_rd(8'h88, rd, st);
      check("dec_word_after", rd, 32'h0008_0001);
      check("dec_tx_data", o_tx_data, 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "time limit reached");
   end

endmodule

`default_nettype wire

// File: doc/sample_0_ext_mailbox.md
# sample_0_ext_mailbox

Mailbox target on the external-register window of the `sample_0` register block. It sits directly downstream of that window: it consumes its bus master transactions at window addresses 0x80–0xFF and answers each with a single-cycle done pulse. It contains two FIFOs:
- a host-to-device TX FIFO, written by register pushes and drained by a valid/ready stream;
- a device-to-host RX FIFO, filled by a stream and drained by register pops.

## Interface
Parameters:
- `BASE_ADDRESS`, 8'h80: window base; offset = `i_address - BASE_ADDRESS`, bits [6:0].
- `DEPTH`, 8: entries per FIFO; power of two, 2..128.
- `DATA_WIDTH`, 32: bus and stream width; fixed at 32.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_request`  in  1  bus request; held by the master until `o_done`.
- `i_address`  in  8  byte address.
- `i_direction`  in  1  1 = write, 0 = read.
- `i_write_data`  in  32  write data.
- `o_done`  out  1  one-cycle completion pulse.
- `o_read_data`  out  32  read data, valid with `o_done`.
- `o_status`  out  2  2'b00 = OK, 2'b10 = slave error; valid with `o_done`.
- `o_tx_valid`  out  1  TX FIFO not empty.
- `o_tx_data`  out  32  TX FIFO head.
- `i_tx_ready`  in  1  stream sink accepts.
- `i_rx_valid`  in  1  stream source offers data.
- `i_rx_data`  in  32  stream data.
- `o_rx_ready`  out  1  RX FIFO not full.
- `o_rx_irq`  out  1  level: RX FIFO not empty.

## Operation
Register map (offsets):
- **0x00 TX_DATA.**
  - Write pushes `i_write_data`. If the TX FIFO is full: no push, error status.
  - Read returns 0 with OK status.
- **0x04 RX_DATA.**
  - Read pops and returns the head with OK status. If the RX FIFO is empty: returns 0, error status, no pop.
  - Write is ignored with OK status.
- **0x08 STATUS** (read-only; writes are ignored with OK status). Field layout:
  - [7:0] tx_count
  - [15:8] rx_count
  - [16] tx_full
  - [17] tx_empty
  - [18] rx_full
  - [19] rx_empty
  - remaining bits read 0
- **0x0C CONTROL** (write-only, self-clearing). Reads return 0 with OK status.
  - Writing bit0 = 1 flushes TX.
  - Writing bit1 = 1 flushes RX.
- **Any other offset:** read data 0, error status, no side effect.

FSM, two states:
- **IDLE:** if `i_request` is high and `o_done` is low, perform the access in this cycle → RESP.
- **RESP:** `o_done` = 1 for exactly one cycle with registered `o_read_data` and `o_status` → IDLE.

Counting rules:
- Counts are `$clog2(DEPTH)+1` bits, zero-extended into STATUS.
- Full ⇔ count == DEPTH.
- Pointers wrap modulo DEPTH.

Simultaneous events:
- **Register push + stream pop on TX in the same cycle:** both take effect; count unchanged. Applies when the FIFO is non-empty.
- **Push when full with a concurrent stream pop:** still rejected. The full check uses the registered count.
- **Stream push + register pop on RX in the same cycle:** both take effect.
- **Flush vs. same-cycle push/pop on that FIFO:** flush wins. Count → 0, pointers → 0, the pushed word is dropped.
  - A CONTROL write flushing RX concurrent with `i_rx_valid && o_rx_ready` drops the stream word. The handshake still completes from the source's view.

Reset (asynchronous, any time, including mid-transaction):
- Both FIFOs empty; FSM → IDLE.
- Output values:
  - `o_done` = 0
  - `o_read_data` = 0
  - `o_status` = 0
  - `o_tx_valid` = 0
  - `o_rx_ready` = 1
  - `o_rx_irq` = 0
  - `o_tx_data` = 0
- An interrupted transaction gets no `o_done`; the master reissues it.

## Timing
- Bus latency:
  - Request sampled in cycle N; `o_done` in cycle N+1.
  - The master deasserts in N+2 at the earliest.
  - Back-to-back accesses complete every 2 cycles.
- FIFO effects are visible to STATUS, `o_tx_valid` and `o_rx_irq` from cycle N+1.
- `o_tx_data` is the head entry, valid whenever `o_tx_valid` is high. The pop occurs at a clock edge with `o_tx_valid && i_tx_ready`.
- `o_rx_ready` depends only on the registered count. There is no combinational path from `i_rx_valid` or `i_tx_ready` to any output.
- Flush completes at the CONTROL-write edge: FIFO empty in N+1.

## Test plan
- **Reset mid-request:** assert `rst` during RESP → `o_done` drops immediately. After release: STATUS read returns 0x000A_0000 (tx_empty and rx_empty set).
- **TX fill, DEPTH=8:** write 0x1..0x8 to 0x80 → all OK. 9th write → status 2'b10 and tx_count stays 8. Then, with `i_tx_ready` high, the stream emits 1..8 in order.
- **RX path:**
  - Drive 3 words A, B, C on the stream → `o_rx_irq` = 1.
  - Reads of 0x84 return A, B, C with OK status.
  - 4th read → data 0, status 2'b10, `o_rx_irq` = 0.
- **Simultaneous:** TX holding 4 entries, register push in the same cycle as a stream pop → tx_count stays 4 and data order is preserved across wrap-around. Run 20 iterations.
- **Flush collision:** write CONTROL = 0x2 while `i_rx_valid` = 1 → rx_count = 0 next cycle and the word is not stored. Also write CONTROL = 0x1 with TX non-empty → `o_tx_valid` = 0 at N+1.
- **Decode:** read offset 0x10 and write offset 0x7C → data 0, status 2'b10, and STATUS unchanged.
